id_stage_fwd: RTL and testbench
===============================

# id_stage_fwd

Registered MIPS decode stage: decodes one 32-bit instruction per cycle and drives regfile read ports. It resolves operands with EX/MEM forwarding, detects load-use hazards, and holds results in an integrated ID/EX pipeline register. It sits between the IF/ID register and the EX stage, replacing the combinational decoder plus separate ID/EX latch.

## Interface
- `PC_W`, 32, PC width carried to EX
- `FWD_EN`, 1, 1 = forward from EX/MEM; 0 = stall on any RAW match instead
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `pc_i`, `inst_i`, `inst_valid_i`  in  PC_W/32/1  instruction from IF/ID
- `reg1_data_i`, `reg2_data_i`  in  32  regfile read data
- `reg1_read_o`, `reg2_read_o`, `reg1_addr_o`, `reg2_addr_o`  out  1/1/5/5  combinational regfile reads
- `ex_wreg_i`, `ex_wd_i`, `ex_wdata_i`  in  1/5/32  EX-stage writeback (combinational ALU result)
- `mem_wreg_i`, `mem_wd_i`, `mem_wdata_i`  in  1/5/32  MEM-stage writeback
- `stall_i`  in  1  downstream hold; `flush_i`  in  1  kill pending decode
- `stall_req_o`  out  1  combinational; IF/ID must hold
- `ex_valid_o`, `ex_pc_o`, `ex_aluop_o`, `ex_alusel_o`  out  1/PC_W/8/3  registered
- `ex_reg1_o`, `ex_reg2_o`, `ex_wd_o`, `ex_wreg_o`, `ex_is_load_o`, `ex_instvalid_o`  out  32/32/5/1/1/1  registered

## Operation
- Decoded: ORI 0x0D, ANDI 0x0C, XORI 0x0E (imm zero-extended); LUI 0x0F (`{imm,16'h0}`); ADDIU 0x09, LW 0x23 (sign-extended); SPECIAL 0x00 funct OR 0x25, AND 0x24, XOR 0x26, NOR 0x27, ADDU 0x21, SUBU 0x23, SLL 0x00, SRL 0x02, SRA 0x03.
- I-type: rs→port1, imm→reg2, wd = rt. R-type: rs, rt; wd = rd. Shifts: reg1 = `{27'b0, sa}`, reg2 = rt, port1 unread.
- Unknown opcode/funct: `instvalid` = 0, `wreg` = 0, aluop NOP. Captured, not trapped.
- `wd` = 0 forces `wreg` = 0. All-zero word decodes as valid NOP.
- Operand mux per port, in priority order:
  - address 0 gives 0;
  - EX match (`ex_wreg_i && ex_wd_i==addr`) gives `ex_wdata_i`;
  - MEM match gives `mem_wdata_i`;
  - else regfile data.
  - Unread port gives imm or shift value. Port 2 reads `reg2_data_i`.
- Load-use: `ex_valid_o && ex_is_load_o && ex_wreg_o` and `ex_wd_o` equals a read, nonzero address. This asserts `stall_req_o`.
- FWD_EN=0: any EX or MEM RAW match on a read, nonzero address asserts `stall_req_o`. The mux uses regfile data only.
- `inst_valid_i` = 0: no reads, `stall_req_o` = 0, bubble captured.

## Timing
- Reset (`rst`=0, async): all registered outputs 0, aluop `EXE_NOP_OP`, alusel `EXE_RES_NOP`. Release is synchronous to the next edge.
- Decode and operand selection are combinational in cycle N. The ID/EX register updates at the edge ending N, so latency is 1.
- Edge priority:
  1. `flush_i`: bubble, valid = 0, wreg = 0, is_load = 0.
  2. `stall_i`: hold all registers.
  3. `stall_req_o`: insert bubble.
  4. Otherwise capture decode.
- `stall_req_o` is forced 0 during `flush_i`. During `stall_i` it is still computed; IF/ID holds either way.
- Load-use costs exactly one bubble. The next cycle sees `ex_is_load_o` = 0 and resolves the load through the MEM forward.
- EX and MEM matching the same register: EX wins (younger).
- Async reset mid-stall clears the register immediately. There is no pending state besides the register.

## Structure
- Shared defines header holds opcodes, funct codes, `EXE_*_OP` (8 bit), `EXE_RES_*` (3 bit), `NOPRegAddr`, `ZeroWord`, and the `RstEnable` polarity (now 0).
- One sub-module, `id_operand_mux` (forward select, used per port), instanced twice.
- Decode is a single `always @(*)` with defaults before the case. The register block is a separate `always @(posedge clk or negedge rst)`.

## Test plan
- Reset, then `ori $1,$0,0x1100` (0x34011100): next cycle `ex_wd_o`=1, `ex_wreg_o`=1, `ex_reg1_o`=0, `ex_reg2_o`=0x00001100, aluop `EXE_OR_OP`.
- `ex_wd_i`=2, `ex_wdata_i`=0xDEADBEEF, `mem_wd_i`=2, `mem_wdata_i`=0x1; decode `or $3,$2,$2`: both operands 0xDEADBEEF. Repeat with FWD_EN=0: `stall_req_o`=1 and bubble captured.
- `lw $4,0($5)` then `addu $6,$4,$4`: one cycle with `stall_req_o`=1 and `ex_valid_o`=0, then addu is captured using the MEM forward.
- `addiu $7,$0,0xFFFF`: `ex_reg2_o`=0xFFFFFFFF. `lui $7,0x1234`: `ex_reg2_o`=0x12340000. `sra $8,$9,4`: `ex_reg1_o`=4.
- `stall_i`=1 for 3 cycles: outputs frozen. Then `flush_i`=1 with `stall_req_o` pending: bubble captured, `stall_req_o`=0. `ori $0,$1,5`: `ex_wreg_o`=0.
- Invalid opcode 0x3F: `ex_instvalid_o`=0, `ex_wreg_o`=0. Async `rst`=0 mid-cycle: all outputs 0 before the next edge.

Source files
------------

// File: rtl/id_stage_fwd_pkg.sv
// Shared decode constants and the ID/EX payload type for the forwarding
// decode stage.
package id_stage_fwd_pkg;

   localparam int unsigned REG_W    = 32;
   localparam int unsigned RADDR_W  = 5;
   localparam int unsigned ALUOP_W  = 8;
   localparam int unsigned ALUSEL_W = 3;

   // Reset is asserted when rst equals this value.
   localparam logic RST_ENABLE = 1'b0;

   localparam logic [REG_W-1:0]   ZERO_WORD    = 32'h0000_0000;
   localparam logic [RADDR_W-1:0] NOP_REG_ADDR = 5'd0;

   // Primary opcodes
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;

   // SPECIAL funct codes
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;

   // ALU operation codes
   localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'h00;
   localparam logic [ALUOP_W-1:0] EXE_SRL_OP   = 8'h02;
   localparam logic [ALUOP_W-1:0] EXE_SRA_OP   = 8'h03;
   localparam logic [ALUOP_W-1:0] EXE_ADDU_OP  = 8'h21;
   localparam logic [ALUOP_W-1:0] EXE_SUBU_OP  = 8'h23;
   localparam logic [ALUOP_W-1:0] EXE_AND_OP   = 8'h24;
   localparam logic [ALUOP_W-1:0] EXE_OR_OP    = 8'h25;
   localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = 8'h26;
   localparam logic [ALUOP_W-1:0] EXE_NOR_OP   = 8'h27;
   localparam logic [ALUOP_W-1:0] EXE_ADDIU_OP = 8'h56;
   localparam logic [ALUOP_W-1:0] EXE_SLL_OP   = 8'h7C;
   localparam logic [ALUOP_W-1:0] EXE_LW_OP    = 8'hE3;

   // ALU result selectors
   localparam logic [ALUSEL_W-1:0] EXE_RES_NOP        = 3'b000;
   localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC      = 3'b001;
   localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT      = 3'b010;
   localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH      = 3'b100;
   localparam logic [ALUSEL_W-1:0] EXE_RES_LOAD_STORE = 3'b111;

   // ID/EX payload, excluding valid and PC.
   typedef struct packed {
      logic [ALUOP_W-1:0]  aluop;
      logic [ALUSEL_W-1:0] alusel;
      logic [REG_W-1:0]    reg1;
      logic [REG_W-1:0]    reg2;
      logic [RADDR_W-1:0]  wd;
      logic                wreg;
      logic                is_load;
      logic                instvalid;
   } idex_t;

   localparam idex_t IDEX_BUBBLE = '{
      aluop:     EXE_NOP_OP,
      alusel:    EXE_RES_NOP,
      reg1:      ZERO_WORD,
      reg2:      ZERO_WORD,
      wd:        NOP_REG_ADDR,
      wreg:      1'b0,
      is_load:   1'b0,
      instvalid: 1'b0
   };

endpackage

// File: rtl/id_stage_fwd_if.sv
// ID/EX output bundle from the decode stage to EX.
//   master: decode stage drives the registered ID/EX contents
//   slave : EX stage consumes them
interface id_stage_fwd_if #(
   parameter int unsigned PC_W = 32
);
   import id_stage_fwd_pkg::*;

   logic                ex_valid_o;
   logic [PC_W-1:0]     ex_pc_o;
   logic [ALUOP_W-1:0]  ex_aluop_o;
   logic [ALUSEL_W-1:0] ex_alusel_o;
   logic [REG_W-1:0]    ex_reg1_o;
   logic [REG_W-1:0]    ex_reg2_o;
   logic [RADDR_W-1:0]  ex_wd_o;
   logic                ex_wreg_o;
   logic                ex_is_load_o;
   logic                ex_instvalid_o;

   modport master (
      output ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o, ex_reg1_o,
             ex_reg2_o, ex_wd_o, ex_wreg_o, ex_is_load_o, ex_instvalid_o
   );

   modport slave (
      input  ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o, ex_reg1_o,
             ex_reg2_o, ex_wd_o, ex_wreg_o, ex_is_load_o, ex_instvalid_o
   );
endinterface

// File: rtl/id_operand_mux.sv
// Per-port operand select: immediate/shift value when the port is unread,
// zero for $0, then EX forward, MEM forward, regfile data.
// Ports:
//   read_i/addr_i      port read enable and register address
//   reg_data_i/alt_i   regfile data and value used when unread
//   ex_*/mem_*         writeback taps of the EX and MEM stages
//   data_o             selected operand (combinational)
//   raw_o              read, nonzero address matching EX or MEM writeback
module id_operand_mux
   import id_stage_fwd_pkg::*;
#(
   parameter bit FWD_EN = 1'b1
) (
   input  logic               read_i,
   input  logic [RADDR_W-1:0] addr_i,
   input  logic [REG_W-1:0]   reg_data_i,
   input  logic [REG_W-1:0]   alt_i,
   input  logic               ex_wreg_i,
   input  logic [RADDR_W-1:0] ex_wd_i,
   input  logic [REG_W-1:0]   ex_wdata_i,
   input  logic               mem_wreg_i,
   input  logic [RADDR_W-1:0] mem_wd_i,
   input  logic [REG_W-1:0]   mem_wdata_i,
   output logic [REG_W-1:0]   data_o,
   output logic               raw_o
);

   logic live_c;
   logic ex_hit_c;
   logic mem_hit_c;

   assign live_c    = read_i && (addr_i != NOP_REG_ADDR);
   assign ex_hit_c  = live_c && ex_wreg_i  && (ex_wd_i  == addr_i);
   assign mem_hit_c = live_c && mem_wreg_i && (mem_wd_i == addr_i);
   assign raw_o     = ex_hit_c || mem_hit_c;

   // EX is checked first: it holds the younger producer.
   always_comb begin
      data_o = reg_data_i;
      if (!read_i) begin
         data_o = alt_i;
      end else if (addr_i == NOP_REG_ADDR) begin
         data_o = ZERO_WORD;
      end else if (FWD_EN && ex_hit_c) begin
         data_o = ex_wdata_i;
      end else if (FWD_EN && mem_hit_c) begin
         data_o = mem_wdata_i;
      end
   end

endmodule

// File: rtl/id_stage_fwd.sv
// Registered MIPS decode stage with EX/MEM forwarding, load-use detection
// and an integrated ID/EX register.
// Ports:
//   clk, rst                 clock, async active-low reset
//   pc_i/inst_i/inst_valid_i instruction from IF/ID
//   reg*_data_i              regfile read data
//   reg*_read_o/reg*_addr_o  regfile read requests (combinational)
//   ex_*/mem_* inputs        EX/MEM writeback taps for forwarding
//   stall_i/flush_i          downstream hold / kill pending decode
//   stall_req_o              IF/ID hold request (combinational)
//   ex_o                     registered ID/EX contents
module id_stage_fwd
   import id_stage_fwd_pkg::*;
#(
   parameter int unsigned PC_W   = 32,
   parameter bit          FWD_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PC_W-1:0]    pc_i,
   input  logic [31:0]        inst_i,
   input  logic               inst_valid_i,
   input  logic [REG_W-1:0]   reg1_data_i,
   input  logic [REG_W-1:0]   reg2_data_i,
   output logic               reg1_read_o,
   output logic               reg2_read_o,
   output logic [RADDR_W-1:0] reg1_addr_o,
   output logic [RADDR_W-1:0] reg2_addr_o,
   input  logic               ex_wreg_i,
   input  logic [RADDR_W-1:0] ex_wd_i,
   input  logic [REG_W-1:0]   ex_wdata_i,
   input  logic               mem_wreg_i,
   input  logic [RADDR_W-1:0] mem_wd_i,
   input  logic [REG_W-1:0]   mem_wdata_i,
   input  logic               stall_i,
   input  logic               flush_i,
   output logic               stall_req_o,
   id_stage_fwd_if.master     ex_o
);

   logic [5:0]         op_c;
   logic [5:0]         funct_c;
   logic [RADDR_W-1:0] rs_c;
   logic [RADDR_W-1:0] rt_c;
   logic [RADDR_W-1:0] rd_c;
   logic [4:0]         sa_c;
   logic [15:0]        imm_c;

   assign op_c    = inst_i[31:26];
   assign rs_c    = inst_i[25:21];
   assign rt_c    = inst_i[20:16];
   assign rd_c    = inst_i[15:11];
   assign sa_c    = inst_i[10:6];
   assign imm_c   = inst_i[15:0];
   assign funct_c = inst_i[5:0];

   logic               rd1_c;
   logic               rd2_c;
   logic [REG_W-1:0]   alt1_c;
   logic [REG_W-1:0]   alt2_c;
   idex_t              dec_c;

   // Instruction decode; unknown encodings fall through as invalid NOPs.
   always_comb begin
      dec_c  = IDEX_BUBBLE;
      rd1_c  = 1'b0;
      rd2_c  = 1'b0;
      alt1_c = ZERO_WORD;
      alt2_c = ZERO_WORD;
      case (op_c)
         OP_SPECIAL: begin
            case (funct_c)
               FN_OR, FN_AND, FN_XOR, FN_NOR, FN_ADDU, FN_SUBU: begin
                  rd1_c           = 1'b1;
                  rd2_c           = 1'b1;
                  dec_c.wd        = rd_c;
                  dec_c.wreg      = 1'b1;
                  dec_c.instvalid = 1'b1;
                  dec_c.aluop     = {2'b00, funct_c};
                  dec_c.alusel    = ((funct_c == FN_ADDU) || (funct_c == FN_SUBU))
                                    ? EXE_RES_ARITH : EXE_RES_LOGIC;
               end
               FN_SLL, FN_SRL, FN_SRA: begin
                  rd2_c           = 1'b1;
                  alt1_c          = REG_W'(sa_c);
                  dec_c.wd        = rd_c;
                  dec_c.wreg      = 1'b1;
                  dec_c.instvalid = 1'b1;
                  dec_c.alusel    = EXE_RES_SHIFT;
                  dec_c.aluop     = (funct_c == FN_SLL) ? EXE_SLL_OP :
                                    (funct_c == FN_SRL) ? EXE_SRL_OP : EXE_SRA_OP;
               end
               default: ;
            endcase
         end
         OP_ORI, OP_ANDI, OP_XORI: begin
            rd1_c           = 1'b1;
            alt2_c          = REG_W'(imm_c);
            dec_c.wd        = rt_c;
            dec_c.wreg      = 1'b1;
            dec_c.instvalid = 1'b1;
            dec_c.alusel    = EXE_RES_LOGIC;
            dec_c.aluop     = (op_c == OP_ORI)  ? EXE_OR_OP  :
                              (op_c == OP_ANDI) ? EXE_AND_OP : EXE_XOR_OP;
         end
         OP_LUI: begin
            rd1_c           = 1'b1;
            alt2_c          = {imm_c, 16'h0000};
            dec_c.wd        = rt_c;
            dec_c.wreg      = 1'b1;
            dec_c.instvalid = 1'b1;
            dec_c.alusel    = EXE_RES_LOGIC;
            dec_c.aluop     = EXE_OR_OP;
         end
         OP_ADDIU, OP_LW: begin
            rd1_c           = 1'b1;
            alt2_c          = {{16{imm_c[15]}}, imm_c};
            dec_c.wd        = rt_c;
            dec_c.wreg      = 1'b1;
            dec_c.instvalid = 1'b1;
            dec_c.is_load   = (op_c == OP_LW);
            dec_c.alusel    = (op_c == OP_LW) ? EXE_RES_LOAD_STORE : EXE_RES_ARITH;
            dec_c.aluop     = (op_c == OP_LW) ? EXE_LW_OP : EXE_ADDIU_OP;
         end
         default: ;
      endcase
      // Writes to $0 are discarded at decode.
      if (dec_c.wd == NOP_REG_ADDR) begin
         dec_c.wreg = 1'b0;
      end
   end

   assign reg1_read_o = inst_valid_i && rd1_c;
   assign reg2_read_o = inst_valid_i && rd2_c;
   assign reg1_addr_o = rs_c;
   assign reg2_addr_o = rt_c;

   logic [REG_W-1:0] op1_c;
   logic [REG_W-1:0] op2_c;
   logic             raw1_c;
   logic             raw2_c;

   id_operand_mux #(.FWD_EN(FWD_EN)) u_mux1 (
      .read_i      (reg1_read_o),
      .addr_i      (reg1_addr_o),
      .reg_data_i  (reg1_data_i),
      .alt_i       (alt1_c),
      .ex_wreg_i   (ex_wreg_i),
      .ex_wd_i     (ex_wd_i),
      .ex_wdata_i  (ex_wdata_i),
      .mem_wreg_i  (mem_wreg_i),
      .mem_wd_i    (mem_wd_i),
      .mem_wdata_i (mem_wdata_i),
      .data_o      (op1_c),
      .raw_o       (raw1_c)
   );

   id_operand_mux #(.FWD_EN(FWD_EN)) u_mux2 (
      .read_i      (reg2_read_o),
      .addr_i      (reg2_addr_o),
      .reg_data_i  (reg2_data_i),
      .alt_i       (alt2_c),
      .ex_wreg_i   (ex_wreg_i),
      .ex_wd_i     (ex_wd_i),
      .ex_wdata_i  (ex_wdata_i),
      .mem_wreg_i  (mem_wreg_i),
      .mem_wd_i    (mem_wd_i),
      .mem_wdata_i (mem_wdata_i),
      .data_o      (op2_c),
      .raw_o       (raw2_c)
   );

   logic            valid_q;
   logic [PC_W-1:0] pc_q;
   idex_t           idex_q;
   idex_t           idex_d;

   always_comb begin
      idex_d      = dec_c;
      idex_d.reg1 = op1_c;
      idex_d.reg2 = op2_c;
   end

   // Load in EX whose result a live read needs: ALU tap is not the data yet.
   logic ld_use_c;
   assign ld_use_c = valid_q && idex_q.is_load && idex_q.wreg &&
                     ((reg1_read_o && (rs_c != NOP_REG_ADDR) && (idex_q.wd == rs_c)) ||
                      (reg2_read_o && (rt_c != NOP_REG_ADDR) && (idex_q.wd == rt_c)));

   assign stall_req_o = inst_valid_i && !flush_i &&
                        (ld_use_c || (!FWD_EN && (raw1_c || raw2_c)));

   // ID/EX register: flush > hold > bubble > capture.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         idex_q  <= IDEX_BUBBLE;
      end else if (flush_i) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         idex_q  <= IDEX_BUBBLE;
      end else if (!stall_i) begin
         if (stall_req_o || !inst_valid_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            idex_q  <= IDEX_BUBBLE;
         end else begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            idex_q  <= idex_d;
         end
      end
   end

   assign ex_o.ex_valid_o     = valid_q;
   assign ex_o.ex_pc_o        = pc_q;
   assign ex_o.ex_aluop_o     = idex_q.aluop;
   assign ex_o.ex_alusel_o    = idex_q.alusel;
   assign ex_o.ex_reg1_o      = idex_q.reg1;
   assign ex_o.ex_reg2_o      = idex_q.reg2;
   assign ex_o.ex_wd_o        = idex_q.wd;
   assign ex_o.ex_wreg_o      = idex_q.wreg;
   assign ex_o.ex_is_load_o   = idex_q.is_load;
   assign ex_o.ex_instvalid_o = idex_q.instvalid;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed bench for id_stage_fwd: one forwarding instance and one
// stall-on-RAW instance share stimulus; expected ID/EX contents are queued
// when an instruction is presented and compared after the capturing edge.
module tb_id_stage_fwd;
   import id_stage_fwd_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i, inst_i;
   logic        inst_valid_i;
   logic [31:0] reg1_data_i, reg2_data_i;
   logic        ex_wreg_i, mem_wreg_i;
   logic [4:0]  ex_wd_i, mem_wd_i;
   logic [31:0] ex_wdata_i, mem_wdata_i;
   logic        stall_i, flush_i;

   logic        reg1_read_o, reg2_read_o, stall_req_o;
   logic [4:0]  reg1_addr_o, reg2_addr_o;
   logic        nf_reg1_read_o, nf_reg2_read_o, nf_stall_req_o;
   logic [4:0]  nf_reg1_addr_o, nf_reg2_addr_o;

   id_stage_fwd_if #(.PC_W(32)) ex_if ();
   id_stage_fwd_if #(.PC_W(32)) nf_if ();

   always #5 clk = ~clk;

   // Regfile model: port 1 returns 0x1000_00aa, port 2 returns 0x2000_00aa.
   assign reg1_data_i = 32'h1000_0000 | 32'(reg1_addr_o);
   assign reg2_data_i = 32'h2000_0000 | 32'(reg2_addr_o);

   id_stage_fwd #(.PC_W(32), .FWD_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
      .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
      .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
      .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
      .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
      .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
      .stall_i(stall_i), .flush_i(flush_i), .stall_req_o(stall_req_o), .ex_o(ex_if)
   );

   id_stage_fwd #(.PC_W(32), .FWD_EN(1'b0)) dut_nf (
      .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
      .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
      .reg1_read_o(nf_reg1_read_o), .reg2_read_o(nf_reg2_read_o),
      .reg1_addr_o(nf_reg1_addr_o), .reg2_addr_o(nf_reg2_addr_o),
      .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
      .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
      .stall_i(stall_i), .flush_i(flush_i), .stall_req_o(nf_stall_req_o), .ex_o(nf_if)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [4:0]  wd;
      logic        wreg;
      logic        ld;
      logic        iv;
   } exp_t;

   exp_t sb[$];
   exp_t sb_nf[$];
   int   errors = 0;
   int   checks = 0;

   function automatic exp_t mk(input logic v, input logic [31:0] pc, input logic [7:0] op,
                               input logic [2:0] sel, input logic [31:0] r1, input logic [31:0] r2,
                               input logic [4:0] wd, input logic wreg, input logic ld,
                               input logic iv);
      exp_t e;
      e.valid = v; e.pc = pc; e.aluop = op; e.alusel = sel; e.r1 = r1; e.r2 = r2;
      e.wd = wd; e.wreg = wreg; e.ld = ld; e.iv = iv;
      return e;
   endfunction

   function automatic exp_t obs_dut();
      return mk(ex_if.ex_valid_o, ex_if.ex_pc_o, ex_if.ex_aluop_o, ex_if.ex_alusel_o,
                ex_if.ex_reg1_o, ex_if.ex_reg2_o, ex_if.ex_wd_o, ex_if.ex_wreg_o,
                ex_if.ex_is_load_o, ex_if.ex_instvalid_o);
   endfunction

   function automatic exp_t obs_nf();
      return mk(nf_if.ex_valid_o, nf_if.ex_pc_o, nf_if.ex_aluop_o, nf_if.ex_alusel_o,
                nf_if.ex_reg1_o, nf_if.ex_reg2_o, nf_if.ex_wd_o, nf_if.ex_wreg_o,
                nf_if.ex_is_load_o, nf_if.ex_instvalid_o);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Bubbles only pin valid/wreg/is_load; full compares everything.
   task automatic cmp(input string who, input exp_t o, input exp_t e, input bit full);
      chk({who, ".valid"},   32'(o.valid), 32'(e.valid));
      chk({who, ".wreg"},    32'(o.wreg),  32'(e.wreg));
      chk({who, ".is_load"}, 32'(o.ld),    32'(e.ld));
      if (e.valid || full) begin
         chk({who, ".pc"},        o.pc,          e.pc);
         chk({who, ".aluop"},     32'(o.aluop),  32'(e.aluop));
         chk({who, ".alusel"},    32'(o.alusel), 32'(e.alusel));
         chk({who, ".reg1"},      o.r1,          e.r1);
         chk({who, ".reg2"},      o.r2,          e.r2);
         chk({who, ".wd"},        32'(o.wd),     32'(e.wd));
         chk({who, ".instvalid"}, 32'(o.iv),     32'(e.iv));
      end
   endtask

   task automatic push(input exp_t e, input exp_t e_nf);
      sb.push_back(e);
      sb_nf.push_back(e_nf);
   endtask

   // Advance one edge, then pop and compare both scoreboards.
   task automatic tick(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0 || sb_nf.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard underflow observed=empty expected=entry", tag);
      end else begin
         e = sb.pop_front();
         cmp({tag, "/fwd"}, obs_dut(), e, 1'b0);
         e = sb_nf.pop_front();
         cmp({tag, "/nofwd"}, obs_nf(), e, 1'b0);
      end
      @(negedge clk);
   endtask

   task automatic present(input logic [31:0] pc, input logic [31:0] inst);
      pc_i = pc;
      inst_i = inst;
      inst_valid_i = 1'b1;
   endtask

   exp_t bub, e_ori, e_lw, e_z;

   initial begin
      bub = mk(1'b0, 32'h0, EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      pc_i = '0; inst_i = '0; inst_valid_i = 1'b0;
      ex_wreg_i = 1'b0; ex_wd_i = '0; ex_wdata_i = '0;
      mem_wreg_i = 1'b0; mem_wd_i = '0; mem_wdata_i = '0;
      stall_i = 1'b0; flush_i = 1'b0;

      // Reset state before any edge
      #2;
      cmp("reset/fwd", obs_dut(), bub, 1'b1);
      cmp("reset/nofwd", obs_nf(), bub, 1'b1);
      chk("reset.stall_req", 32'(stall_req_o), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // ori $1,$0,0x1100
      present(32'h100, 32'h3401_1100);
      #1;
      chk("ori.reg1_read", 32'(reg1_read_o), 32'd1);
      chk("ori.reg2_read", 32'(reg2_read_o), 32'd0);
      e_ori = mk(1'b1, 32'h100, EXE_OR_OP, EXE_RES_LOGIC, 32'h0, 32'h0000_1100, 5'd1, 1'b1, 1'b0, 1'b1);
      push(e_ori, e_ori);
      tick("ori");

      // or $3,$2,$2 with EX and MEM both writing $2: EX wins; no-forward stalls
      ex_wreg_i = 1'b1; ex_wd_i = 5'd2; ex_wdata_i = 32'hDEAD_BEEF;
      mem_wreg_i = 1'b1; mem_wd_i = 5'd2; mem_wdata_i = 32'h0000_0001;
      present(32'h104, 32'h0042_1825);
      #1;
      chk("or.stall_req/fwd", 32'(stall_req_o), 32'd0);
      chk("or.stall_req/nofwd", 32'(nf_stall_req_o), 32'd1);
      push(mk(1'b1, 32'h104, EXE_OR_OP, EXE_RES_LOGIC, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd3, 1'b1, 1'b0, 1'b1), bub);
      tick("or_fwd");

      // lw $4,0($5)
      ex_wreg_i = 1'b0; mem_wreg_i = 1'b0;
      present(32'h108, 32'h8CA4_0000);
      e_lw = mk(1'b1, 32'h108, EXE_LW_OP, EXE_RES_LOAD_STORE, 32'h1000_0005, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1);
      push(e_lw, e_lw);
      tick("lw");

      // addu $6,$4,$4 with load in EX: one bubble
      ex_wreg_i = 1'b1; ex_wd_i = 5'd4; ex_wdata_i = 32'h0000_0014;
      present(32'h10C, 32'h0084_3021);
      #1;
      chk("loaduse.stall_req/fwd", 32'(stall_req_o), 32'd1);
      chk("loaduse.stall_req/nofwd", 32'(nf_stall_req_o), 32'd1);
      push(bub, bub);
      tick("loaduse_bubble");

      // Load now in MEM: forwarded from MEM
      ex_wreg_i = 1'b0;
      mem_wreg_i = 1'b1; mem_wd_i = 5'd4; mem_wdata_i = 32'hCAFE_F00D;
      #1;
      chk("addu.stall_req/fwd", 32'(stall_req_o), 32'd0);
      chk("addu.stall_req/nofwd", 32'(nf_stall_req_o), 32'd1);
      push(mk(1'b1, 32'h10C, EXE_ADDU_OP, EXE_RES_ARITH, 32'hCAFE_F00D, 32'hCAFE_F00D, 5'd6, 1'b1, 1'b0, 1'b1), bub);
      tick("addu_memfwd");
      mem_wreg_i = 1'b0;

      // addiu $7,$0,0xFFFF
      present(32'h110, 32'h2407_FFFF);
      e_z = mk(1'b1, 32'h110, EXE_ADDIU_OP, EXE_RES_ARITH, 32'h0, 32'hFFFF_FFFF, 5'd7, 1'b1, 1'b0, 1'b1);
      push(e_z, e_z);
      tick("addiu");

      // lui $7,0x1234
      present(32'h114, 32'h3C07_1234);
      e_z = mk(1'b1, 32'h114, EXE_OR_OP, EXE_RES_LOGIC, 32'h0, 32'h1234_0000, 5'd7, 1'b1, 1'b0, 1'b1);
      push(e_z, e_z);
      tick("lui");

      // sra $8,$9,4
      present(32'h118, 32'h0009_4103);
      #1;
      chk("sra.reg1_read", 32'(reg1_read_o), 32'd0);
      e_z = mk(1'b1, 32'h118, EXE_SRA_OP, EXE_RES_SHIFT, 32'h4, 32'h2000_0009, 5'd8, 1'b1, 1'b0, 1'b1);
      push(e_z, e_z);
      tick("sra");

      // lw again, then hold for three cycles with a dependent addu waiting
      present(32'h11C, 32'h8CA4_0000);
      e_lw.pc = 32'h11C;
      push(e_lw, e_lw);
      tick("lw2");

      stall_i = 1'b1;
      present(32'h120, 32'h0084_3021);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold.stall_req/fwd", 32'(stall_req_o), 32'd1);
         push(e_lw, e_lw);
         tick("hold");
      end

      // Flush wins over the pending load-use request
      stall_i = 1'b0;
      flush_i = 1'b1;
      #1;
      chk("flush.stall_req/fwd", 32'(stall_req_o), 32'd0);
      chk("flush.stall_req/nofwd", 32'(nf_stall_req_o), 32'd0);
      push(bub, bub);
      tick("flush");
      flush_i = 1'b0;

      // ori $0,$1,5: write to $0 dropped
      present(32'h124, 32'h3420_0005);
      e_z = mk(1'b1, 32'h124, EXE_OR_OP, EXE_RES_LOGIC, 32'h1000_0001, 32'h5, 5'd0, 1'b0, 1'b0, 1'b1);
      push(e_z, e_z);
      tick("ori_r0");

      // Invalid opcode 0x3F: captured, not valid
      present(32'h128, 32'hFC00_0000);
      e_z = mk(1'b1, 32'h128, EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      push(e_z, e_z);
      tick("invalid");

      // All-zero word is a valid NOP
      present(32'h12C, 32'h0000_0000);
      e_z = mk(1'b1, 32'h12C, EXE_SLL_OP, EXE_RES_SHIFT, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
      push(e_z, e_z);
      tick("nop_word");

      // No valid instruction: no reads, no stall, bubble
      present(32'h130, 32'h0084_3021);
      inst_valid_i = 1'b0;
      ex_wreg_i = 1'b1; ex_wd_i = 5'd4;
      #1;
      chk("novalid.reg1_read", 32'(reg1_read_o), 32'd0);
      chk("novalid.stall_req/nofwd", 32'(nf_stall_req_o), 32'd0);
      push(bub, bub);
      tick("novalid");
      ex_wreg_i = 1'b0;

      // Capture something, then async reset mid-cycle
      present(32'h134, 32'h3401_1100);
      e_ori.pc = 32'h134;
      push(e_ori, e_ori);
      tick("ori2");
      #2;
      rst = 1'b0;
      #1;
      cmp("async_rst/fwd", obs_dut(), bub, 1'b1);
      cmp("async_rst/nofwd", obs_nf(), bub, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      inst_valid_i = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
